// File: rtl/bitbalancer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bitbalancer_pkg
// Description : Shared state encoding and width helpers for the constant-
//               popcount pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
package bitbalancer_pkg;

   // Generator control states: waiting for a request / streaming patterns.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Width of the requested-ones count: must hold 0..width (and overflow values).
   function automatic int count_width(input int width);
      return $clog2(width + 1);
   endfunction

   // Width of the beat ordinal; C(width, k) always fits in width-1 bits.
   function automatic int index_width(input int width);
      return width - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ones_next_pattern.sv
`default_nettype none
// ============================================================================
// Module      : ones_next_pattern
// Description : Combinational successor: next larger WIDTH-bit value with the
//               same number of set bits. A zero input is passed through.
// Revision    : 1.0 - initial release
// ============================================================================
module ones_next_pattern
   import bitbalancer_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CW    = count_width(WIDTH)
) (
   input  logic [WIDTH-1:0] i_pattern,
   output logic [WIDTH-1:0] o_next
);

   logic [CW-1:0]    w_tz;        // trailing zeros below the lowest set run
   logic [CW-1:0]    w_run;       // length of the lowest set run
   logic             w_tz_done;
   logic             w_run_done;
   logic [WIDTH-1:0] w_run_bits;  // pattern with the lowest run moved to bit 0
   logic [WIDTH-1:0] w_low_bit;   // lowest set bit of the pattern
   logic [WIDTH-1:0] w_bumped;    // run cleared, bit above the run set
   logic [WIDTH-1:0] w_fill;      // remaining run-1 ones packed at the LSBs

   // Locate the lowest set bit (count trailing zeros).
   always_comb begin
      w_tz      = '0;
      w_tz_done = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (!w_tz_done) begin
            if (i_pattern[i]) w_tz_done = 1'b1;
            else              w_tz      = w_tz + 1'b1;
         end
      end
   end

   assign w_run_bits = i_pattern >> w_tz;

   // Measure the run of ones starting at the lowest set bit (trailing ones).
   always_comb begin
      w_run      = '0;
      w_run_done = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (!w_run_done) begin
            if (w_run_bits[i]) w_run      = w_run + 1'b1;
            else               w_run_done = 1'b1;
         end
      end
   end

   // Adding the lowest set bit carries through the run, moving its top bit up
   // one place; the other run-1 ones are re-inserted at the bottom.
   assign w_low_bit = WIDTH'(1) << w_tz;
   assign w_bumped  = i_pattern + w_low_bit;
   assign w_fill    = (WIDTH'(1) << (w_run - 1'b1)) - WIDTH'(1);
   assign o_next    = (w_run == '0) ? i_pattern : (w_bumped | w_fill);

endmodule
`default_nettype wire

// File: rtl/ones_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : ones_pattern_gen
// Description : On request for k ones, streams every WIDTH-bit pattern with
//               popcount k in ascending order over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module ones_pattern_gen
   import bitbalancer_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CW    = count_width(WIDTH),
   localparam int IW    = index_width(WIDTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [CW-1:0] req_count,
   output logic          req_err,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [IW-1:0] out_index,
   output logic          out_last
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_k;
   logic [WIDTH-1:0] r_data;
   logic [IW-1:0]    r_index;
   logic             r_err;

   logic             w_load;
   logic             w_advance;
   logic             w_err_nxt;
   logic             w_last;
   logic [WIDTH-1:0] w_first;
   logic [WIDTH-1:0] w_last_pattern;
   logic [WIDTH-1:0] w_next;

   ones_next_pattern #(
      .WIDTH (WIDTH)
   ) u_next (
      .i_pattern (r_data),
      .o_next    (w_next)
   );

   // First pattern: k ones at the LSBs. Last pattern: k ones at the MSBs.
   // Shifting an all-ones word keeps k=0 and k=WIDTH exact without overflow.
   assign w_first        = ~({WIDTH{1'b1}} << req_count);
   assign w_last_pattern = ~({WIDTH{1'b1}} >> r_k);
   assign w_last         = (r_state == ST_EMIT) && (r_data == w_last_pattern);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode: accept/reject requests in IDLE, step or finish in EMIT.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_advance   = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_count > CW'(WIDTH)) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_EMIT;
               end
            end
         end
         ST_EMIT: begin
            if (out_ready) begin
               if (w_last) w_state_nxt = ST_IDLE;
               else        w_advance   = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: capture k and the first pattern, then step to the successor.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_k     <= '0;
         r_data  <= '0;
         r_index <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_err_nxt;
         if (w_load) begin
            r_k     <= req_count;
            r_data  <= w_first;
            r_index <= '0;
         end else if (w_advance) begin
            r_data  <= w_next;
            r_index <= r_index + 1'b1;
         end
      end
   end

   assign req_ready = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_EMIT);
   assign out_last  = w_last;
   assign out_data  = r_data;
   assign out_index = r_index;
   assign req_err   = r_err;

endmodule
`default_nettype wire

// File: doc/ones_pattern_gen.md
ONES_PATTERN_GEN -- requirements
Module: ones_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pattern width in bits; supported range 4..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  block can accept a request.
REQ-006 SHALL have port req_count  input  $clog2(WIDTH+1)  requested number of ones k.
REQ-007 SHALL have port req_err  output  1  one-cycle pulse: accepted request had k > WIDTH.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid pattern.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the pattern.
REQ-010 SHALL have port out_data  output  WIDTH  pattern containing exactly k ones.
REQ-011 SHALL have port out_index  output  WIDTH-1  zero-based ordinal of out_data within the sequence.
REQ-012 SHALL have port out_last  output  1  out_data is the final pattern of the sequence.

Function
REQ-013 SHALL implement two states: IDLE (req_ready=1, out_valid=0) and EMIT (req_ready=0, out_valid=1).
REQ-014 SHALL accept a request on a rising edge where req_valid && req_ready; k captured from req_count.
REQ-015 SHALL, on accepting k > WIDTH, remain in IDLE and assert req_err for exactly the next cycle.
REQ-016 SHALL, on accepting k <= WIDTH, enter EMIT next cycle with out_data = (1<<k)-1 and out_index = 0 (latency 1 cycle).
REQ-017 SHALL emit every WIDTH-bit pattern with popcount k exactly once, in strictly ascending numeric order; total count C(WIDTH,k).
REQ-018 SHALL advance on a rising edge where out_valid && out_ready: out_data to the next larger value of equal popcount, out_index increments by 1.
REQ-019 SHALL hold out_data, out_index, out_last stable while out_valid && !out_ready.
REQ-020 SHALL assert out_last combinationally when out_data == ((1<<k)-1) << (WIDTH-k).
REQ-021 SHALL return to IDLE on the handshake of the out_last beat; req_ready=1 the following cycle; no idle bubble beyond that.
REQ-022 SHALL treat k=0 and k=WIDTH as single-beat sequences (0x00 / all-ones) with out_last=1 on index 0.
REQ-023 SHALL ignore req_valid and req_count while in EMIT.
REQ-024 SHALL compute the next pattern without a divider: lowest set run located by trailing-zero/ones logic, run's top bit moved up one, remaining run bits packed to LSBs.

Reset
REQ-025 SHALL, when reset is high at a rising edge, enter IDLE with out_valid=0, out_data=0, out_index=0, out_last=0, req_err=0, captured k=0.
REQ-026 SHALL let reset mid-sequence abort it; the partial sequence is never resumed.
REQ-027 SHALL give reset priority over any simultaneous handshake.

Structure
REQ-028 SHALL place the state encoding (IDLE, EMIT) and the count/index width localparams in shared package bitbalancer_pkg.
REQ-029 SHALL place the equal-popcount successor logic in one combinational sub-module ones_next_pattern (input WIDTH-bit pattern, output successor).
REQ-030 SHALL keep all registers in ones_pattern_gen; ones_next_pattern holds no state.

Verification
REQ-031 SHALL cover: WIDTH=8, k=2, out_ready=1 -> 28 beats 0x03,0x05,0x06,0x09,...,0xC0; out_index 0..27; out_last only on 0xC0.
REQ-032 SHALL cover: k=0 then k=8 -> single beat 0x00 then 0xFF, each with out_last=1, out_index=0.
REQ-033 SHALL cover: k=4 with random out_ready stalls -> 70 beats, all distinct, each popcount 4 (checked against ones_detector), data stable during stalls.
REQ-034 SHALL cover: req_count=9 -> req_err high exactly one cycle, out_valid stays 0, req_ready stays 1.
REQ-035 SHALL cover: reset at beat 10 of k=3 -> next cycle out_valid=0, out_data=0; new k=1 request yields 0x01 first.
REQ-036 SHALL cover: back-to-back requests k=1 then k=7 held on req_valid -> second accepted the cycle after the last k=1 beat (0x80); 8 beats 0x7F..0xFE follow.
